clk_div_gen: RTL and testbench
==============================

Name: clk_div_gen

Overview:
- Parametrised, runtime-reconfigurable clock-divider bank. It generates NUM_CLKS registered divided clocks and matching rising-edge tick strobes from one reference clock.
- Each channel has a programmable divisor and phase delay. A global lock indicator is provided.
- Sits beside the board PLL and feeds the low-rate video/audio domains. It replaces fixed-frequency PLL outputs where software must retune rates without recompiling.

Parameters:
- NUM_CLKS, 3, number of output channels (1..16).
- DIV_W, 8, width of divisor and phase fields.
- RST_DIV, 2, divisor loaded into every channel at reset (≥2).
- LOCK_CYCLES, 16, consecutive restart-free cycles required before locked asserts (≥1).

Ports:
- refclk  in  1  reference clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted; equals locked.
- cfg_sel  in  4  target channel index.
- cfg_div  in  DIV_W  divide ratio.
- cfg_phase  in  DIV_W  start delay in refclk cycles.
- cfg_err  out  1  one-cycle pulse on accepted request with cfg_sel ≥ NUM_CLKS.
- sync  in  1  one-cycle pulse: restart all channels with their stored settings.
- outclk  out  NUM_CLKS  divided clocks, registered.
- tick  out  NUM_CLKS  one-cycle pulse in each cycle where outclk[i] rises.
- locked  out  1  all channels running stably.

Behaviour:
- Reset (rst_n=0, async): outclk=0, tick=0, cfg_err=0, locked=0. Every channel stores div=RST_DIV and phase=0, and its state is DELAY with delay counter 0.
- Per-channel FSM has two states:
  - DELAY: outclk=0, tick=0, delay counter increments each edge. When counter == phase, the next edge performs START.
  - RUN: cnt counts 0..eff_div-1 and wraps.
- START: cnt←0, outclk←1, tick←1 (tick high one cycle only).
- Effective divisor: eff_div = (div<2) ? 2 : div. hi = eff_div>>1.
- In RUN: outclk=1 while cnt<hi, else 0. Odd divisors give hi high cycles and eff_div-hi low cycles (e.g. 5 → 2 high, 3 low).
- Tick asserts in exactly the cycles where cnt==0.
- Timing from reset: with phase=0, START happens on the first edge after rst_n deasserts. With phase=p, START happens on edge p+1.
- Restart event is any of: reset release, accepted config for a valid channel, or sync.
- Config handshake:
  - Accept when cfg_valid && cfg_ready on an edge.
  - Valid channel: store div/phase for cfg_sel, that channel enters DELAY with counter 0, and other channels are undisturbed.
  - Invalid channel: no state change, cfg_err pulses the following cycle, locked unaffected.
- sync: all channels enter DELAY with counter 0, using stored settings. They then start aligned (equal phases start on the same edge).
- sync coinciding with an accepted config: the new config is stored first, then all channels restart.
- Lock counter:
  - Cleared on any restart event; saturates at LOCK_CYCLES.
  - locked=1 while counter==LOCK_CYCLES.
  - locked drops in the cycle after an accepted valid config or sync.
  - Consequently, when not locked, cfg_valid is held off (cfg_ready=0). Requesters must hold cfg_valid and stable data until accepted.
- Phase values ≥ eff_div are legal and give pure start delay.
- rst_n asserted mid-operation immediately forces all outputs to reset values.

Optional Feature:
- Macro CLKGEN_DUTY_EN.
- Defined: adds input cfg_hi (DIV_W) sampled with each accepted config, and each channel stores hi.
  - hi=0 is treated as eff_div>>1.
  - hi ≥ eff_div is clamped to eff_div-1, so outclk always toggles.
  - tick unchanged.
- Undefined: no cfg_hi port; hi fixed at eff_div>>1 as above.

Test Plan:
- Reset release with defaults (NUM_CLKS=3, RST_DIV=2) → all outclk toggle 1,0,1,0 from the first edge. tick high on edges 1,3,5. locked rises after 16 edges. cfg_ready follows locked.
- Config ch1 div=5 phase=3 once locked → ch1 low 4 edges after accept, then 2 high/3 low repeating. Ch0/ch2 undisturbed. locked low for 16 cycles then high.
- Config ch0 div=0 → behaves as divide-by-2. Config cfg_sel=7 → cfg_err single pulse, locked stays 1, no output change.
- Channels set div=4/6/8 then sync pulse → all three outclk rise on the same edge. Ticks coincide every 24 cycles.
- cfg_valid asserted while locked=0 → not accepted until locked; settings applied on the first locked edge.
- rst_n pulsed low mid-run (ch1 div=5 configured) → outputs 0 immediately. After release, ch1 is back to divide-by-2 and locked=0 for 16 cycles.

Source files
------------

// File: rtl/clk_div_gen.sv
// Runtime-reconfigurable bank of NUM_CLKS registered clock dividers with tick strobes and a lock flag.
// Optional macro CLKGEN_DUTY_EN adds a per-channel programmable high time (cfg_hi).
module clk_div_gen #(
  parameter int NUM_CLKS    = 3,
  parameter int DIV_W       = 8,
  parameter int RST_DIV     = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_phase,
`ifdef CLKGEN_DUTY_EN
  input  logic [DIV_W-1:0]    cfg_hi,
`endif
  output logic                cfg_err,
  input  logic                sync,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] tick,
  output logic                locked
);

  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {ST_DELAY, ST_RUN} state_e;

  state_e              state_q [NUM_CLKS];
  state_e              state_d [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_q   [NUM_CLKS];  // delay count in DELAY, period count in RUN
  logic [DIV_W-1:0]    cnt_d   [NUM_CLKS];
  logic [DIV_W-1:0]    div_q   [NUM_CLKS];
  logic [DIV_W-1:0]    div_d   [NUM_CLKS];
  logic [DIV_W-1:0]    phase_q [NUM_CLKS];
  logic [DIV_W-1:0]    phase_d [NUM_CLKS];
`ifdef CLKGEN_DUTY_EN
  logic [DIV_W-1:0]    hi_q    [NUM_CLKS];
  logic [DIV_W-1:0]    hi_d    [NUM_CLKS];
`endif
  logic [DIV_W-1:0]    eff_w   [NUM_CLKS];
  logic [DIV_W-1:0]    hi_w    [NUM_CLKS];
  logic [NUM_CLKS-1:0] outclk_q, outclk_d;
  logic [NUM_CLKS-1:0] tick_q, tick_d;
  logic                cfg_err_q, cfg_err_d;
  logic [LCK_W-1:0]    lock_q, lock_d;

  logic accept;
  logic sel_ok;

  assign locked    = (lock_q == LCK_W'(LOCK_CYCLES));
  assign cfg_ready = locked;
  assign accept    = cfg_valid && cfg_ready;
  assign sel_ok    = int'(cfg_sel) < NUM_CLKS;
  assign outclk    = outclk_q;
  assign tick      = tick_q;
  assign cfg_err   = cfg_err_q;

  // Effective divisor and high time, derived from the stored settings.
  always_comb begin
    for (int i = 0; i < NUM_CLKS; i++) begin
      eff_w[i] = (div_q[i] < DIV_W'(2)) ? DIV_W'(2) : div_q[i];
      hi_w[i]  = eff_w[i] >> 1;
`ifdef CLKGEN_DUTY_EN
      if (hi_q[i] >= eff_w[i])    hi_w[i] = eff_w[i] - DIV_W'(1);
      else if (hi_q[i] != '0)     hi_w[i] = hi_q[i];
`endif
    end
  end

  always_comb begin : next_state_p
    logic [DIV_W-1:0] nxt;
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    nxt       = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    phase_d   = phase_q;
`ifdef CLKGEN_DUTY_EN
    hi_d      = hi_q;
`endif
    outclk_d  = '0;
    tick_d    = '0;
    cfg_err_d = accept && !sel_ok;

    for (int i = 0; i < NUM_CLKS; i++) begin
      if (accept && sel_ok && (int'(cfg_sel) == i)) begin
        div_d[i]   = cfg_div;
        phase_d[i] = cfg_phase;
`ifdef CLKGEN_DUTY_EN
        hi_d[i]    = cfg_hi;
`endif
      end
      if (sync || (accept && sel_ok && (int'(cfg_sel) == i))) begin
        state_d[i] = ST_DELAY;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          ST_DELAY: begin
            if (cnt_q[i] == phase_q[i]) begin
              state_d[i]  = ST_RUN;
              cnt_d[i]    = '0;
              outclk_d[i] = 1'b1;
              tick_d[i]   = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
          end
          ST_RUN: begin
            nxt         = (cnt_q[i] == eff_w[i] - DIV_W'(1)) ? '0 : cnt_q[i] + DIV_W'(1);
            cnt_d[i]    = nxt;
            outclk_d[i] = nxt < hi_w[i];
            tick_d[i]   = nxt == '0;
          end
          default: ;
        endcase
      end
    end

    // Lock counter clears on any restart and saturates at LOCK_CYCLES.
    if (sync || (accept && sel_ok)) lock_d = '0;
    else if (locked)                lock_d = lock_q;
    else                            lock_d = lock_q + LCK_W'(1);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the settings arrays are reset too, because every channel must restart at RST_DIV.
      for (int i = 0; i < NUM_CLKS; i++) begin
        state_q[i] <= ST_DELAY;
        cnt_q[i]   <= '0;
        div_q[i]   <= DIV_W'(RST_DIV);
        phase_q[i] <= '0;
`ifdef CLKGEN_DUTY_EN
        hi_q[i]    <= '0;
`endif
      end
      outclk_q  <= '0;
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
      lock_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
`ifdef CLKGEN_DUTY_EN
      hi_q      <= hi_d;
`endif
      outclk_q  <= outclk_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
      lock_q    <= lock_d;
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Randomised bench for clk_div_gen: an edge-indexed arithmetic model predicts every output each cycle.
module tb_clk_div_gen;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int RDIV = 2;
  localparam int LOCK = 16;

  logic          refclk = 1'b0;
  logic          rst_n  = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [3:0]    cfg_sel = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [DW-1:0] cfg_phase = '0;
  logic          cfg_err;
  logic          sync = 1'b0;
  logic [N-1:0]  outclk;
  logic [N-1:0]  tick;
  logic          locked;

  int checks = 0;
  int fails  = 0;

  // Model: each channel is described by the absolute edge on which it starts.
  int e;
  int m_div [N];
  int m_phase [N];
  int m_start [N];
  int m_last;
  bit m_err;

  clk_div_gen #(.NUM_CLKS(N), .DIV_W(DW), .RST_DIV(RDIV), .LOCK_CYCLES(LOCK)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .sync(sync), .outclk(outclk), .tick(tick), .locked(locked)
  );

  always #5 refclk = ~refclk;

  function automatic int eff_of(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic logic [8:0] model_exp();
    logic [N-1:0] eo, et;
    logic lk;
    int k;
    eo = '0;
    et = '0;
    for (int i = 0; i < N; i++) begin
      if (e >= m_start[i]) begin
        k     = (e - m_start[i]) % eff_of(m_div[i]);
        eo[i] = k < (eff_of(m_div[i]) / 2);
        et[i] = k == 0;
      end
    end
    lk = (e - m_last) >= LOCK;
    return {eo, et, lk, lk, m_err};
  endfunction

  function automatic logic [8:0] dut_obs();
    return {outclk, tick, locked, cfg_ready, cfg_err};
  endfunction

  task automatic model_reset();
    e      = 0;
    m_last = 0;
    m_err  = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_div[i]   = RDIV;
      m_phase[i] = 0;
      m_start[i] = 1;
    end
  endtask

  // One refclk edge: drive inputs, advance the model, return expected outputs 1 time unit after the edge.
  task automatic cyc(input bit v, input int sel, input int d, input int p, input bit s,
                     output logic [8:0] exp, output bit acc);
    bit lk_before;
    cfg_valid = v;
    cfg_sel   = 4'(sel);
    cfg_div   = DW'(d);
    cfg_phase = DW'(p);
    sync      = s;
    @(posedge refclk);
    lk_before = (e - m_last) >= LOCK;
    acc = v && lk_before;
    e++;
    m_err = acc && (sel >= N);
    if (acc && sel < N) begin
      m_div[sel]   = d;
      m_phase[sel] = p;
      m_start[sel] = e + p + 1;
      m_last       = e;
    end
    if (s) begin
      for (int i = 0; i < N; i++) m_start[i] = e + m_phase[i] + 1;
      m_last = e;
    end
    #1;
    exp = model_exp();
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    bit acc;
    rst_n = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    checks++;
    if (dut_obs() !== 9'b0) begin
      fails++;
      $display("FAIL reset_hold: got %b want %b", dut_obs(), 9'b0);
    end
    @(negedge refclk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 24; c++) begin
      cyc(0, 0, 0, 0, 0, exp, acc);
      checks++;
      if (dut_obs() !== exp) begin
        fails++;
        $display("FAIL reset_release edge %0d: got %b want %b", e, dut_obs(), exp);
      end
    end
  endtask

  // Holds the request until the model reports acceptance, then idles for `idle` edges.
  task automatic test_config(input string name, input int sel, input int d, input int p, input int idle);
    logic [8:0] exp;
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      cyc(1, sel, d, p, 0, exp, acc);
      guard++;
      checks++;
      if (dut_obs() !== exp) begin
        fails++;
        $display("FAIL %s request edge %0d: got %b want %b", name, e, dut_obs(), exp);
      end
    end
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL %s never accepted: got locked=%b want 1", name, locked);
    end
    for (int c = 0; c < idle; c++) begin
      cyc(0, 0, 0, 0, 0, exp, acc);
      checks++;
      if (dut_obs() !== exp) begin
        fails++;
        $display("FAIL %s run edge %0d: got %b want %b", name, e, dut_obs(), exp);
      end
    end
  endtask

  task automatic test_sync();
    logic [8:0] exp;
    bit acc;
    int all_ticks;
    test_config("sync_cfg0", 0, 4, 0, 0);
    test_config("sync_cfg1", 1, 6, 0, 0);
    test_config("sync_cfg2", 2, 8, 0, 0);
    cyc(0, 0, 0, 0, 1, exp, acc);
    checks++;
    if (dut_obs() !== exp) begin
      fails++;
      $display("FAIL sync_pulse edge %0d: got %b want %b", e, dut_obs(), exp);
    end
    all_ticks = 0;
    for (int c = 0; c < 50; c++) begin
      cyc(0, 0, 0, 0, 0, exp, acc);
      if (tick === 3'b111) all_ticks++;
      checks++;
      if (dut_obs() !== exp) begin
        fails++;
        $display("FAIL sync_run edge %0d: got %b want %b", e, dut_obs(), exp);
      end
    end
    // Aligned start plus two 24-cycle coincidences fall inside the 50-edge window.
    checks++;
    if (all_ticks !== 3) begin
      fails++;
      $display("FAIL sync_coincide: got %0d want 3", all_ticks);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    bit acc;
    bit v, s;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 99) < 30);
      s = ($urandom_range(0, 99) < 2);
      cyc(v, $urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 20), s, exp, acc);
      checks++;
      if (dut_obs() !== exp) begin
        fails++;
        $display("FAIL random edge %0d: got %b want %b", e, dut_obs(), exp);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [8:0] exp;
    bit acc;
    test_config("mid_cfg", 1, 5, 0, 12);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_obs() !== 9'b0) begin
      fails++;
      $display("FAIL reset_async: got %b want %b", dut_obs(), 9'b0);
    end
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(0, 0, 0, 0, 0, exp, acc);
      checks++;
      if (dut_obs() !== exp) begin
        fails++;
        $display("FAIL reset_midrun edge %0d: got %b want %b", e, dut_obs(), exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_config("cfg_ch1_div5", 1, 5, 3, 30);
    test_config("cfg_ch0_div0", 0, 0, 0, 20);
    test_config("cfg_bad_sel", 7, 9, 1, 10);
    test_config("back_to_back_a", 2, 3, 2, 0);
    test_config("back_to_back_b", 0, 7, 5, 25);
    test_sync();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
